// File: rtl/pcs_sync_link_controller_if.sv
// Status/control bundle between the PMA/management side and the sync link controller.
// Scalar clock and reset are carried as plain ports on the controller.
interface pcs_sync_link_controller_if #(parameter int CNT_W = 8);
  logic             signal_detect_raw;
  logic             mr_loopback;
  logic             code_sync_status;
  logic             cnt_clr;
  logic             signal_detect;
  logic             sync_rst_n;
  logic             link_up;
  logic [2:0]       state;
  logic [CNT_W-1:0] loss_count;
  logic [CNT_W-1:0] timeout_count;

  modport master (
    output signal_detect_raw, mr_loopback, code_sync_status, cnt_clr,
    input  signal_detect, sync_rst_n, link_up, state, loss_count, timeout_count
  );

  modport slave (
    input  signal_detect_raw, mr_loopback, code_sync_status, cnt_clr,
    output signal_detect, sync_rst_n, link_up, state, loss_count, timeout_count
  );
endinterface

// File: rtl/pcs_sync_link_controller.sv
// 1000BASE-X receive sync sequencer: debounces signal detect, resets the
// synchronizer, times acquisition, retries and reports link state.
//
//   state        | meaning
//   WAIT_SIGNAL  | no effective signal detect; synchronizer held in reset
//   RESET_SYNC   | synchronizer reset pulse, RESET_CYCLES long
//   WAIT_SYNC    | synchronizer running, waiting up to SYNC_TIMEOUT for sync
//   LINK_UP      | code sync acquired
//   HOLDOFF      | back-off after timeout or sync loss before retrying
module pcs_sync_link_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_CYCLES    = 4,
  parameter int SYNC_TIMEOUT    = 64,
  parameter int HOLDOFF_CYCLES  = 16,
  parameter int CNT_W           = 8
) (
  input logic                          clk,
  input logic                          mr_main_reset,
  pcs_sync_link_controller_if.slave    bus
);

  localparam int MAX_A = (SYNC_TIMEOUT > HOLDOFF_CYCLES) ? SYNC_TIMEOUT : HOLDOFF_CYCLES;
  localparam int MAX_T = (MAX_A > RESET_CYCLES) ? MAX_A : RESET_CYCLES;
  localparam int TMR_W = $clog2(MAX_T) + 1;
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES) + 1;

  typedef enum logic [2:0] {
    S_WAIT_SIGNAL = 3'd0,
    S_RESET_SYNC  = 3'd1,
    S_WAIT_SYNC   = 3'd2,
    S_LINK_UP     = 3'd3,
    S_HOLDOFF     = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               sd_q, sd_d;
  logic               sync_rst_n_q, sync_rst_n_d;
  logic               link_up_q, link_up_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic [CNT_W-1:0]   tmo_q, tmo_d;
  logic               sd_eff, timer_tc, loss_inc, tmo_inc;

  assign sd_eff   = bus.mr_loopback | sd_q;
  assign timer_tc = (timer_q == '0);

  always_ff @(posedge clk or negedge mr_main_reset) begin
    if (!mr_main_reset) begin
      state_q      <= S_WAIT_SIGNAL;
      timer_q      <= '0;
      db_cnt_q     <= '0;
      sd_q         <= 1'b0;
      sync_rst_n_q <= 1'b0;
      link_up_q    <= 1'b0;
      loss_q       <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      db_cnt_q     <= db_cnt_d;
      sd_q         <= sd_d;
      sync_rst_n_q <= sync_rst_n_d;
      link_up_q    <= link_up_d;
      loss_q       <= loss_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_tc ? '0 : timer_q - 1'b1;
    db_cnt_d = '0;
    sd_d     = sd_q;
    loss_inc = 1'b0;
    tmo_inc  = 1'b0;

    // Raw must disagree for DEBOUNCE_CYCLES consecutive cycles before we follow it.
    if (bus.signal_detect_raw != sd_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        sd_d = ~sd_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_WAIT_SIGNAL: begin
        if (sd_eff) begin
          state_d = S_RESET_SYNC;
          timer_d = TMR_W'(RESET_CYCLES - 1);
        end
      end
      S_RESET_SYNC: begin
        if (timer_tc) begin
          state_d = S_WAIT_SYNC;
          timer_d = TMR_W'(SYNC_TIMEOUT - 1);
        end
      end
      S_WAIT_SYNC: begin
        if (bus.code_sync_status) begin
          state_d = S_LINK_UP;
        end else if (timer_tc) begin
          state_d = S_HOLDOFF;
          timer_d = TMR_W'(HOLDOFF_CYCLES - 1);
          tmo_inc = 1'b1;
        end
      end
      S_LINK_UP: begin
        if (!bus.code_sync_status) begin
          state_d  = S_HOLDOFF;
          timer_d  = TMR_W'(HOLDOFF_CYCLES - 1);
          loss_inc = 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (timer_tc) begin
          state_d = S_RESET_SYNC;
          timer_d = TMR_W'(RESET_CYCLES - 1);
        end
      end
      default: begin
        state_d = S_WAIT_SIGNAL;
        timer_d = '0;
      end
    endcase

    // Losing signal detect overrides every other transition.
    if (!sd_eff && state_q != S_WAIT_SIGNAL) begin
      state_d  = S_WAIT_SIGNAL;
      timer_d  = '0;
      tmo_inc  = 1'b0;
      loss_inc = (state_q == S_LINK_UP);
    end

    if (bus.cnt_clr)                   loss_d = '0;
    else if (loss_inc && ~&loss_q)     loss_d = loss_q + 1'b1;
    else                               loss_d = loss_q;

    if (bus.cnt_clr)                   tmo_d = '0;
    else if (tmo_inc && ~&tmo_q)       tmo_d = tmo_q + 1'b1;
    else                               tmo_d = tmo_q;

    sync_rst_n_d = (state_d == S_WAIT_SYNC) || (state_d == S_LINK_UP);
    link_up_d    = (state_d == S_LINK_UP);
  end

  assign bus.signal_detect = sd_q;
  assign bus.sync_rst_n    = sync_rst_n_q;
  assign bus.link_up       = link_up_q;
  assign bus.state         = state_q;
  assign bus.loss_count    = loss_q;
  assign bus.timeout_count = tmo_q;

endmodule

// File: tb/tb_pcs_sync_link_controller.sv
// Directed bench for pcs_sync_link_controller: expectations are queued as
// stimulus is applied and checked against the DUT after the clock edges.
module tb_pcs_sync_link_controller;
  localparam int SEL_STATE = 0, SEL_SD = 1, SEL_SRN = 2, SEL_LINK = 3, SEL_LOSS = 4, SEL_TMO = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic mr_main_reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  pcs_sync_link_controller_if #(.CNT_W(8)) bus ();

  pcs_sync_link_controller dut (
    .clk           (clk),
    .mr_main_reset (mr_main_reset),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      SEL_STATE: observe = {29'd0, bus.state};
      SEL_SD:    observe = {31'd0, bus.signal_detect};
      SEL_SRN:   observe = {31'd0, bus.sync_rst_n};
      SEL_LINK:  observe = {31'd0, bus.link_up};
      SEL_LOSS:  observe = {24'd0, bus.loss_count};
      default:   observe = {24'd0, bus.timeout_count};
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.sel = sel; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s observed %0d expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (bus.state === target) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_state observed %0d expected %0d", bus.state, target);
    end
  endtask

  initial begin
    bus.signal_detect_raw = 1'b0;
    bus.mr_loopback       = 1'b0;
    bus.code_sync_status  = 1'b0;
    bus.cnt_clr           = 1'b0;
    tick(2);
    push("rst_state", SEL_STATE, 0); push("rst_sd", SEL_SD, 0); push("rst_srn", SEL_SRN, 0);
    push("rst_link", SEL_LINK, 0);   push("rst_loss", SEL_LOSS, 0); push("rst_tmo", SEL_TMO, 0);
    drain();
    mr_main_reset = 1'b1;
    tick(1);

    // glitch shorter than the debounce window
    bus.signal_detect_raw = 1'b1;
    tick(3);
    bus.signal_detect_raw = 1'b0;
    tick(5);
    push("glitch_sd", SEL_SD, 0); push("glitch_state", SEL_STATE, 0);
    drain();

    // steady detect -> debounce -> RESET_SYNC -> WAIT_SYNC
    bus.signal_detect_raw = 1'b1;
    tick(3);
    push("db_sd_early", SEL_SD, 0);
    drain();
    tick(1);
    push("db_sd", SEL_SD, 1); push("db_state", SEL_STATE, 0);
    drain();
    tick(1);
    push("rs_state", SEL_STATE, 1); push("rs_srn", SEL_SRN, 0);
    drain();
    tick(3);
    push("rs_state_end", SEL_STATE, 1); push("rs_srn_end", SEL_SRN, 0);
    drain();
    tick(1);
    push("ws_state", SEL_STATE, 2); push("ws_srn", SEL_SRN, 1);
    drain();

    // acquisition timeout then holdoff
    tick(63);
    push("to_state_last", SEL_STATE, 2); push("to_cnt_before", SEL_TMO, 0);
    drain();
    tick(1);
    push("to_state", SEL_STATE, 4); push("to_cnt", SEL_TMO, 1); push("to_srn", SEL_SRN, 0);
    drain();
    tick(15);
    push("ho_state_last", SEL_STATE, 4);
    drain();
    tick(1);
    push("ho_exit", SEL_STATE, 1);
    drain();
    tick(4);
    push("ws2_state", SEL_STATE, 2);
    drain();

    // sync on the 10th cycle of WAIT_SYNC, then loss of sync
    tick(9);
    bus.code_sync_status = 1'b1;
    tick(1);
    push("lu_state", SEL_STATE, 3); push("lu_link", SEL_LINK, 1); push("lu_srn", SEL_SRN, 1);
    drain();
    bus.code_sync_status = 1'b0;
    tick(1);
    push("loss_state", SEL_STATE, 4); push("loss_link", SEL_LINK, 0); push("loss_cnt", SEL_LOSS, 1);
    drain();

    tick(16);
    tick(4);
    bus.code_sync_status = 1'b1;
    tick(1);
    push("lu2_state", SEL_STATE, 3);
    drain();

    // signal detect drops while linked
    bus.signal_detect_raw = 1'b0;
    tick(4);
    push("sd_drop", SEL_SD, 0); push("sd_drop_state", SEL_STATE, 3);
    drain();
    tick(1);
    push("sdl_state", SEL_STATE, 0); push("sdl_loss", SEL_LOSS, 2); push("sdl_srn", SEL_SRN, 0);
    push("sdl_link", SEL_LINK, 0);
    drain();

    // same drop with loopback holds the link
    bus.signal_detect_raw = 1'b1;
    tick(4);
    wait_state(3, 20);
    bus.mr_loopback       = 1'b1;
    bus.signal_detect_raw = 1'b0;
    tick(6);
    push("lb_state", SEL_STATE, 3); push("lb_link", SEL_LINK, 1); push("lb_sd", SEL_SD, 0);
    push("lb_loss", SEL_LOSS, 2);
    drain();
    bus.mr_loopback = 1'b0;
    tick(1);
    push("lb_off_state", SEL_STATE, 0); push("lb_off_loss", SEL_LOSS, 3);
    drain();

    // saturate loss_count
    bus.mr_loopback       = 1'b1;
    bus.signal_detect_raw = 1'b1;
    for (int i = 0; i < 260; i++) begin
      bus.code_sync_status = 1'b1;
      wait_state(3, 60);
      bus.code_sync_status = 1'b0;
      tick(1);
    end
    push("sat_loss", SEL_LOSS, 255); push("sat_state", SEL_STATE, 4);
    drain();

    // clear wins over a same-cycle loss
    bus.code_sync_status = 1'b1;
    wait_state(3, 60);
    bus.code_sync_status = 1'b0;
    bus.cnt_clr          = 1'b1;
    tick(1);
    bus.cnt_clr = 1'b0;
    push("clr_loss", SEL_LOSS, 0); push("clr_tmo", SEL_TMO, 0); push("clr_state", SEL_STATE, 4);
    drain();

    // one more timeout, then async reset inside WAIT_SYNC
    wait_state(2, 60);
    tick(64);
    push("to2_state", SEL_STATE, 4); push("to2_cnt", SEL_TMO, 1); push("to2_sd", SEL_SD, 1);
    drain();
    wait_state(2, 60);
    tick(3);
    #2 mr_main_reset = 1'b0;
    #1;
    push("ar_state", SEL_STATE, 0); push("ar_sd", SEL_SD, 0); push("ar_srn", SEL_SRN, 0);
    push("ar_link", SEL_LINK, 0);   push("ar_loss", SEL_LOSS, 0); push("ar_tmo", SEL_TMO, 0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
